// File: rtl/switch_input.sv
// -----------------------------------------------------------------------------
// switch_input
//
// Conditions the board switch bank for the register file. Raw switch levels
// pass through a two-flop synchroniser, then through a debouncer that shares
// one candidate register and one stability counter across the whole vector.
// A vector is accepted only once every bit has held still for DEBOUNCE_CYCLES
// edges. The accepted value is then copied to the output on fetch edges only,
// so it stays constant for the rest of each instruction.
//
// Parameters
//   SWITCH_WIDTH     board switch count. The top switch is not brought in.
//                    SW0-7 form the data byte and SW8 is the flag switch.
//   DEBOUNCE_CYCLES  number of edges the synchronised input must stay constant
//                    before it is accepted (2..65535).
//
// Ports
//   clk           system clock, rising edge
//   n_reset       asynchronous active-low reset
//   cycle         one-hot instruction phase; bit `CYCLE_FETCH marks fetch
//   raw_switches  asynchronous switch levels, SW8 at the MSB
//   switches      debounced switch vector, updated on fetch edges only
//   sw8_rise      one-clock pulse after a fetch edge that took SW8 from 0 to 1
//   sw8_fall      one-clock pulse after a fetch edge that took SW8 from 1 to 0
//   settled       high when no input change is pending anywhere in the pipeline
// -----------------------------------------------------------------------------
`ifndef CYCLE_SIZE
`define CYCLE_SIZE 4
`endif
`ifndef CYCLE_FETCH
`define CYCLE_FETCH 0
`endif

module switch_input #(
    parameter int SWITCH_WIDTH    = 10,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    n_reset,
    input  logic [`CYCLE_SIZE-1:0]  cycle,
    input  logic [SWITCH_WIDTH-2:0] raw_switches,
    output logic [SWITCH_WIDTH-2:0] switches,
    output logic                    sw8_rise,
    output logic                    sw8_fall,
    output logic                    settled
);

    localparam int SW_W  = SWITCH_WIDTH - 1;
    localparam int MSB   = SW_W - 1;
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SW_W-1:0]  r_s1;
    logic [SW_W-1:0]  r_s2;
    logic [SW_W-1:0]  r_cand;
    logic [SW_W-1:0]  r_deb;
    logic [SW_W-1:0]  r_switches;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rise;
    logic             r_fall;

    logic w_same;
    logic w_cnt_max;
    logic w_fetch;
    logic w_unused_cycle;

    assign w_same    = (r_s2 == r_cand);
    assign w_cnt_max = (r_cnt == CNT_MAX);
    assign w_fetch   = cycle[`CYCLE_FETCH];

    // Only the fetch bit of the phase vector is used. The other bits are
    // folded here so that they are visibly and deliberately ignored.
    assign w_unused_cycle = ^cycle;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_s1       <= '0;
            r_s2       <= '0;
            r_cand     <= '0;
            r_deb      <= '0;
            r_cnt      <= '0;
            r_switches <= '0;
            r_rise     <= 1'b0;
            r_fall     <= 1'b0;
        end else begin
            r_s1 <= raw_switches;
            r_s2 <= r_s1;

            // The counter is shared by every bit. A change in any bit reloads
            // the candidate and restarts the count, so a vector that is only
            // partly updated can never be accepted.
            if (!w_same) begin
                r_cand <= r_s2;
                r_cnt  <= '0;
            end else if (!w_cnt_max) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_deb <= r_cand;  // counter saturates; keep re-accepting
            end

            // Copy to the output on fetch edges only. The SW8 edge pulses are
            // derived from the old and new MSB, so each pulse lasts exactly
            // the one clock after that fetch edge.
            if (w_fetch) begin
                r_switches <= r_deb;
                r_rise     <=  r_deb[MSB] & ~r_switches[MSB];
                r_fall     <= ~r_deb[MSB] &  r_switches[MSB];
            end else begin
                r_rise <= 1'b0;
                r_fall <= 1'b0;
            end
        end
    end

    assign switches = r_switches;
    assign sw8_rise = r_rise;
    assign sw8_fall = r_fall;
    assign settled  = (r_s1 == r_s2) && (r_s2 == r_cand) &&
                      (r_cand == r_deb) && (r_deb == r_switches);

endmodule

// File: tb/tb_switch_input.sv
// -----------------------------------------------------------------------------
// tb_switch_input
//
// Directed bench for switch_input with DEBOUNCE_CYCLES=4. The cycle generator
// rotates a one-hot phase so that every 4th edge is a fetch edge. The edge
// index counts from each reset release, and an edge is a fetch edge when
// (index % 4) == 0. The expected edge numbers below are worked out by hand:
// a raw change set up before edge E reaches the debounced register at E+6,
// and it reaches the output at the next fetch edge strictly after that.
// -----------------------------------------------------------------------------
`ifndef CYCLE_SIZE
`define CYCLE_SIZE 4
`endif
`ifndef CYCLE_FETCH
`define CYCLE_FETCH 0
`endif

module tb_switch_input;

    logic                   clk;
    logic                   n_reset;
    logic [`CYCLE_SIZE-1:0] cycle;
    logic [8:0]             raw_switches;
    logic [8:0]             switches;
    logic                   sw8_rise;
    logic                   sw8_fall;
    logic                   settled;

    int total;
    int bad;
    int ecnt;

    switch_input #(
        .SWITCH_WIDTH    (10),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk          (clk),
        .n_reset      (n_reset),
        .cycle        (cycle),
        .raw_switches (raw_switches),
        .switches     (switches),
        .sw8_rise     (sw8_rise),
        .sw8_fall     (sw8_fall),
        .settled      (settled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present the phase for edge 'ecnt', take that edge, then sample 1 ns later.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            cycle = '0;
            cycle[ecnt % 4] = 1'b1;
            @(posedge clk);
            #1;
            ecnt++;
        end
    endtask

    task automatic align(input int phase);
        while ((ecnt % 4) != phase) run(1);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h (edge %0d)", tag, obs, exp, ecnt);
        end
        $display("check %-14s edge=%0d observed=%h expected=%h", tag, ecnt, obs, exp);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        ecnt  = 0;
        n_reset = 1'b1;
        raw_switches = 9'h000;
        cycle = 4'b0001;

        // ---- Reset with 1A5 held, then power-up acceptance with an SW8 rise
        #1;
        n_reset = 1'b0;
        raw_switches = 9'h1A5;
        #1;
        chk("rst_sw",      32'(switches), 32'h000);
        chk("rst_rise",    32'(sw8_rise), 32'h0);
        chk("rst_fall",    32'(sw8_fall), 32'h0);
        chk("rst_settled", 32'(settled),  32'h1);
        run(3);
        chk("rst_hold_sw",  32'(switches), 32'h000);
        chk("rst_hold_set", 32'(settled),  32'h1);
        n_reset = 1'b1;
        ecnt = 0;
        // deb is loaded at E6 (phase 2), so switches updates at fetch edge E8
        for (int k = 0; k < 8; k++) begin
            run(1);
            chk("s1_sw_wait", 32'(switches), 32'h000);
            chk("s1_rise_wait", 32'(sw8_rise), 32'h0);
        end
        chk("s1_settled_lo", 32'(settled), 32'h0);
        run(1);
        chk("s1_sw",   32'(switches), 32'h1A5);
        chk("s1_rise", 32'(sw8_rise), 32'h1);
        chk("s1_fall", 32'(sw8_fall), 32'h0);
        run(1);
        chk("s1_rise_end", 32'(sw8_rise), 32'h0);
        chk("s1_settled",  32'(settled),  32'h1);

        // ---- Return to 0 at E10: deb at E16, but fetch E16 sees old deb -> E20
        raw_switches = 9'h000;
        run(10);
        chk("s1b_sw_hold", 32'(switches), 32'h1A5);
        chk("s1b_fall_lo", 32'(sw8_fall), 32'h0);
        run(1);
        chk("s1b_sw",   32'(switches), 32'h000);
        chk("s1b_fall", 32'(sw8_fall), 32'h1);
        chk("s1b_rise", 32'(sw8_rise), 32'h0);
        run(1);
        chk("s1b_fall_end", 32'(sw8_fall), 32'h0);

        // ---- Glitch: 0FF for 3 edges then back to 0; nothing may reach out
        align(1);
        raw_switches = 9'h0FF;
        run(1);
        chk("s3_settled_lo", 32'(settled), 32'h0);
        run(2);
        raw_switches = 9'h000;
        for (int k = 0; k < 12; k++) begin
            run(1);
            chk("s3_sw",   32'(switches), 32'h000);
            chk("s3_rise", 32'(sw8_rise), 32'h0);
            chk("s3_fall", 32'(sw8_fall), 32'h0);
        end
        chk("s3_settled", 32'(settled), 32'h1);

        // ---- 03C set before E43: deb at E49 (phase 1), switches at E52
        align(3);
        raw_switches = 9'h03C;
        for (int k = 0; k < 9; k++) begin
            run(1);
            chk("s2_sw_hold", 32'(switches), 32'h000);
        end
        chk("s2_settled_lo", 32'(settled), 32'h0);
        run(1);
        chk("s2_sw",   32'(switches), 32'h03C);
        chk("s2_rise", 32'(sw8_rise), 32'h0);
        chk("s2_fall", 32'(sw8_fall), 32'h0);
        chk("s2_settled", 32'(settled), 32'h1);

        // ---- Bit 3 toggles every 2 edges for 20 edges, then holds 1 (008)
        align(3);
        for (int k = 0; k < 10; k++) begin
            raw_switches = ((k % 2) == 0) ? 9'h008 : 9'h000;
            run(1);
            chk("s4_sw_tog", 32'(switches), 32'h03C);
            run(1);
            chk("s4_sw_tog", 32'(switches), 32'h03C);
        end
        // final change before E75: deb at E81, switches at fetch E84
        raw_switches = 9'h008;
        for (int k = 0; k < 9; k++) begin
            run(1);
            chk("s4_sw_hold", 32'(switches), 32'h03C);
        end
        run(1);
        chk("s4_sw",   32'(switches), 32'h008);
        chk("s4_rise", 32'(sw8_rise), 32'h0);
        chk("s4_fall", 32'(sw8_fall), 32'h0);

        // ---- SW8 up for 12 edges (from E87) then down for 12 edges (from E99)
        align(3);
        raw_switches = 9'h100;
        for (int k = 0; k < 12; k++) begin
            int e;
            e = ecnt;
            run(1);
            chk("s5_rise", 32'(sw8_rise), 32'(e == 96));
            chk("s5_fall", 32'(sw8_fall), 32'h0);
        end
        chk("s5_sw_hi", 32'(switches), 32'h100);
        raw_switches = 9'h000;
        for (int k = 0; k < 12; k++) begin
            int e;
            e = ecnt;
            run(1);
            chk("s5_fall2", 32'(sw8_fall), 32'(e == 108));
            chk("s5_rise2", 32'(sw8_rise), 32'h0);
        end
        chk("s5_sw_lo",   32'(switches), 32'h000);
        chk("s5_settled", 32'(settled),  32'h1);

        // ---- Reset while 0AA is pending with cnt==2 (after E115)
        raw_switches = 9'h0AA;
        run(5);
        chk("s6_pre_settled", 32'(settled), 32'h0);
        n_reset = 1'b0;
        #1;
        chk("s6_rst_settled", 32'(settled),  32'h1);
        chk("s6_rst_sw",      32'(switches), 32'h000);
        chk("s6_rst_rise",    32'(sw8_rise), 32'h0);
        chk("s6_rst_fall",    32'(sw8_fall), 32'h0);
        run(2);
        chk("s6_rst_hold", 32'(settled), 32'h1);
        // Release before E118: deb at E124 (a fetch edge, so old deb is used),
        // and switches updates at E128
        n_reset = 1'b1;
        for (int k = 0; k < 10; k++) begin
            run(1);
            chk("s6_sw_hold", 32'(switches), 32'h000);
        end
        run(1);
        chk("s6_sw",   32'(switches), 32'h0AA);
        chk("s6_rise", 32'(sw8_rise), 32'h0);
        run(1);
        chk("s6_settled", 32'(settled), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/switch_input.md
SWITCH_INPUT -- requirements
Module: switch_input

Interface
REQ-001 Parameter SWITCH_WIDTH, default 10, board switch count; SW0-7 are the data byte, SW8 is the flag switch, the top switch is excluded.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16, clock edges raw input must stay constant before acceptance; legal range 2..65535.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 n_reset  input  1  asynchronous, active-low reset.
REQ-005 cycle  input  `CYCLE_SIZE  one-hot instruction phase from the cycle generator; bit `CYCLE_FETCH marks fetch.
REQ-006 raw_switches  input  SWITCH_WIDTH-1  asynchronous board switch levels, SW8 at MSB.
REQ-007 switches  output  SWITCH_WIDTH-1  debounced, fetch-aligned switch vector consumed by the register file (SW07 and SW8 registers).
REQ-008 sw8_rise  output  1  one-clock pulse when switches MSB changes 0->1.
REQ-009 sw8_fall  output  1  one-clock pulse when switches MSB changes 1->0.
REQ-010 settled  output  1  high when no input change is pending anywhere in the pipeline.

Function
REQ-011 Two-flop synchroniser: s1 <= raw_switches, s2 <= s1 every edge; no other logic samples raw_switches.
REQ-012 Candidate register cand and counter cnt (width $clog2(DEBOUNCE_CYCLES)) shared across the whole vector.
REQ-013 Edge with s2 != cand: cand <= s2, cnt <= 0, deb unchanged.
REQ-014 Edge with s2 == cand and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
REQ-015 Edge with s2 == cand and cnt == DEBOUNCE_CYCLES-1: deb <= cand, cnt holds (saturates).
REQ-016 Latency: raw change set up before edge E0 appears in deb after edge E(DEBOUNCE_CYCLES+2), i.e. DEBOUNCE_CYCLES+3 edges.
REQ-017 Any change of any bit during debounce restarts the shared count; partial vectors never reach deb.
REQ-018 Glitch returning to the old value before acceptance: cand reloads, deb never changes, no pulses.
REQ-019 Edge with cycle[`CYCLE_FETCH]==1: switches <= deb; otherwise switches holds, so switches is constant through decode 1, decode 2 and execute.
REQ-020 Earliest switches update is the first fetch edge strictly after the edge that loaded deb.
REQ-021 sw8_rise/sw8_fall asserted for exactly the clock following the fetch edge that changed switches MSB; both never high together.
REQ-022 Changes in SW0-7 only produce no pulses.
REQ-023 settled = (s1 == s2) && (s2 == cand) && (cand == deb) && (deb == switches), combinational from registers.
REQ-024 cycle with zero or multiple bits set: only the `CYCLE_FETCH bit matters; no error handling.

Reset
REQ-025 n_reset low asynchronously clears s1, s2, cand, deb, cnt, switches, sw8_rise, sw8_fall to 0; settled reads 1 while raw_switches==0.
REQ-026 Reset mid-debounce discards the pending value; after release, the full DEBOUNCE_CYCLES+3 edge latency restarts from the current raw input.
REQ-027 Release is synchronous-safe: first state change occurs on the first rising edge after n_reset rises.

Verification (DEBOUNCE_CYCLES=4, cycle generator running, fetch every 4th edge)
REQ-028 Reset with raw_switches=9'h1A5 held -> all outputs 0 during reset; switches==9'h1A5 by first fetch edge after 7 edges post-release, sw8_rise pulse one clock.
REQ-029 raw 9'h000 -> 9'h03C held -> deb==9'h03C after 7th edge, switches unchanged during decode/execute, updates at next fetch edge, no sw8 pulses.
REQ-030 raw 9'h000 -> 9'h0FF for 3 edges -> back to 9'h000 -> switches stays 9'h000, no pulses, settled returns high.
REQ-031 raw bit 3 toggles every 2 edges for 20 edges then holds 1 -> switches bit 3 becomes 1 only 7+ edges after final toggle, at a fetch edge.
REQ-032 raw 9'h100 then 9'h000 (each held 12 edges) -> exactly one sw8_rise then one sw8_fall, each single-cycle, aligned after fetch edges.
REQ-033 n_reset pulsed low at cnt==2 with raw=9'h0AA pending -> outputs 0 immediately; switches==9'h0AA only after a full 7-edge debounce and fetch post-release.
